id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Pipeline interlock controller for the ID stage of the MIPS core. Tracks destination registers of the two instructions issued ahead of ID (EX and MEM slots) and sequences the shared multi-cycle HI/LO multiply/divide unit. Each cycle it decides whether the instruction in ID may issue, or whether IF/ID must hold while a bubble goes into ID/EX. Sits beside the decode stage, consuming its register fields, and drives the PC/IF-ID hold, the ID/EX bubble and the mul/div start strobe.

## Interface
Parameters:
- MUL_CYCLES, 4, busy cycles of HI/LO unit after mult/multu issue (1..63)
- DIV_CYCLES, 33, busy cycles after div/divu issue (1..63)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  6  inst[31:26]
- id_func  in  6  inst[5:0]
- id_rs  in  5  inst[25:21]
- id_rt  in  5  inst[20:16]
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_wreg  in  5  destination register after RegDst selection
- id_wen  in  1  instruction writes a GPR
- mem_stall  in  1  downstream memory wait; freezes entire pipe
- stall  out  1  hold PC and IF/ID register
- bubble  out  1  load NOP into ID/EX instead of ID instruction
- issue  out  1  ID instruction advances into EX this cycle
- md_start  out  1  one-cycle start strobe to HI/LO unit
- md_is_div  out  1  valid with md_start: 1 = div/divu, 0 = mult/multu
- md_busy  out  1  HI/LO unit busy

## Operation
- Internal decode (opcode 0 = SPECIAL): is_jr = func 0x08; is_md = func 0x18/0x19/0x1A/0x1B; is_hilo = func 0x10/0x11/0x12/0x13; is_load = opcode 0x20/0x21/0x23/0x24/0x25.
- Tracker: two entries, EX and MEM, each {valid, wen, load, wreg[4:0]}.
  - When mem_stall = 0: MEM <= EX; EX <= ID fields if issue, else an invalid entry.
  - When mem_stall = 1: both entries hold.
- Hazard terms (all gated by id_valid; wreg 0 never matches):
  - load_use: EX.valid & EX.load & ((id_use_rs & id_rs==EX.wreg) | (id_use_rt & id_rt==EX.wreg)).
  - jr_dep: is_jr & ((EX.valid & EX.wen & id_rs==EX.wreg) | (MEM.valid & MEM.load & id_rs==MEM.wreg)).
  - hilo_dep: (is_md | is_hilo) & md_busy.
- hazard = load_use | jr_dep | hilo_dep.
- stall = mem_stall | hazard.
- bubble = hazard & ~mem_stall.
- issue = id_valid & ~stall.
- HI/LO sequencer: 6-bit counter cnt, states IDLE (cnt==0) and BUSY (cnt!=0).
  - On issue & is_md: md_start=1, md_is_div = func[1], cnt <= DIV_CYCLES or MUL_CYCLES.
  - Else if cnt!=0: cnt <= cnt-1.
  - md_busy = (cnt!=0). The counter decrements during mem_stall; the unit runs independently.
- md_start is asserted only on the issue cycle, never while mem_stall=1.

## Timing
- Reset: tracker entries invalid, cnt=0. Outputs stall/bubble/issue/md_start/md_is_div/md_busy are 0, except that stall follows mem_stall combinationally.
- stall, bubble, issue and md_start are combinational from registered state plus current inputs, with zero latency.
- Load-use: exactly one stall cycle. The dependent instruction issues the cycle after, with forwarding from MEM.
- jr after ALU producer: 1 stall. jr after load: 2 stalls.
- mfhi/mflo or a new mul/div following a mul/div issued at cycle t stalls cycles t+1..t+LAT and issues at t+LAT+1.
- Simultaneous mem_stall and hazard: stall=1, bubble=0; the tracker freezes and the hazard is re-evaluated next cycle.
- rst mid-operation clears the tracker and cnt in the same edge; md_busy drops on the next cycle.

## Test plan
- lw $8 then addu $9,$8,$10 (use_rs): cycle after lw issue gives stall=1, bubble=1, issue=0; next cycle issue=1. Exactly one bubble.
- addu $4,... then jr $4: one stall cycle. lw $4 then jr $4: two stall cycles. jr $0 after lw $0: no stall.
- mult (MUL_CYCLES=4) then mflo: md_start=1, md_is_div=0 on the mult issue cycle; md_busy high 4 cycles; mflo stalls 4 cycles, then issues.
- div (DIV_CYCLES=33) followed by an unrelated addu: no stall, md_busy high 33 cycles. A following divu stalls until cnt reaches 0.
- mem_stall=1 for 3 cycles while a load-use hazard is pending: bubble=0 and the tracker is frozen throughout. After release, one bubble, then issue.
- Assert rst during a div busy period: next cycle md_busy=0 and the EX/MEM entries are invalid; a subsequent mfhi issues without stall.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// ID-stage interlock: tracks EX/MEM destination registers, detects load-use,
// jr and HI/LO hazards, and sequences the shared multiply/divide unit.
module id_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic [5:0] id_func,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] id_wreg,
  input  logic       id_wen,
  input  logic       mem_stall,
  output logic       stall,
  output logic       bubble,
  output logic       issue,
  output logic       md_start,
  output logic       md_is_div,
  output logic       md_busy
);

  localparam logic [5:0] MUL_LAT = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LAT = 6'(DIV_CYCLES);

  logic special, is_jr, is_md, is_hilo, is_load;
  assign special = (id_opcode == 6'h00);
  assign is_jr   = special & (id_func == 6'h08);
  assign is_md   = special & (id_func[5:2] == 4'b0110);
  assign is_hilo = special & (id_func[5:2] == 4'b0100);

  always_comb begin
    is_load = 1'b0;
    case (id_opcode)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load = 1'b1;
      default:                           is_load = 1'b0;
    endcase
  end

  logic       ex_vld_q, ex_wen_q, ex_ld_q;
  logic [4:0] ex_wreg_q;
  logic       mem_vld_q, mem_ld_q;
  logic [4:0] mem_wreg_q;
  logic       ex_vld_d, ex_wen_d, ex_ld_d;
  logic [4:0] ex_wreg_d;
  logic       mem_vld_d, mem_ld_d;
  logic [4:0] mem_wreg_d;
  logic [5:0] cnt_q, cnt_d;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  logic ex_rs_hit, ex_rt_hit, mem_rs_hit;
  assign ex_rs_hit  = (ex_wreg_q  != 5'd0) && (id_rs == ex_wreg_q);
  assign ex_rt_hit  = (ex_wreg_q  != 5'd0) && (id_rt == ex_wreg_q);
  assign mem_rs_hit = (mem_wreg_q != 5'd0) && (id_rs == mem_wreg_q);

  logic load_use, jr_dep, hilo_dep, hazard;
  assign load_use = id_valid & ex_vld_q & ex_ld_q &
                    ((id_use_rs & ex_rs_hit) | (id_use_rt & ex_rt_hit));
  assign jr_dep   = id_valid & is_jr &
                    ((ex_vld_q & ex_wen_q & ex_rs_hit) | (mem_vld_q & mem_ld_q & mem_rs_hit));
  assign hilo_dep = id_valid & (is_md | is_hilo) & md_busy;
  assign hazard   = load_use | jr_dep | hilo_dep;

  assign stall     = mem_stall | hazard;
  assign bubble    = hazard & ~mem_stall;
  assign issue     = id_valid & ~stall;
  assign md_start  = issue & is_md;
  assign md_is_div = md_start & id_func[1];
  assign md_busy   = (cnt_q != 6'd0);

  always_comb begin
    ex_vld_d   = ex_vld_q;
    ex_wen_d   = ex_wen_q;
    ex_ld_d    = ex_ld_q;
    ex_wreg_d  = ex_wreg_q;
    mem_vld_d  = mem_vld_q;
    mem_ld_d   = mem_ld_q;
    mem_wreg_d = mem_wreg_q;
    if (!mem_stall) begin
      mem_vld_d  = ex_vld_q;
      mem_ld_d   = ex_ld_q;
      mem_wreg_d = ex_wreg_q;
      ex_vld_d   = issue;
      ex_wen_d   = id_wen;
      ex_ld_d    = is_load;
      ex_wreg_d  = id_wreg;
    end
  end

  // The HI/LO unit keeps counting through mem_stall; it is not part of the pipe.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start)    cnt_d = id_func[1] ? DIV_LAT : MUL_LAT;
    else if (md_busy) cnt_d = cnt_q - 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_vld_q   <= 1'b0;
      ex_wen_q   <= 1'b0;
      ex_ld_q    <= 1'b0;
      ex_wreg_q  <= 5'd0;
      mem_vld_q  <= 1'b0;
      mem_ld_q   <= 1'b0;
      mem_wreg_q <= 5'd0;
      cnt_q      <= 6'd0;
    end else begin
      ex_vld_q   <= ex_vld_d;
      ex_wen_q   <= ex_wen_d;
      ex_ld_q    <= ex_ld_d;
      ex_wreg_q  <= ex_wreg_d;
      mem_vld_q  <= mem_vld_d;
      mem_ld_q   <= mem_ld_d;
      mem_wreg_q <= mem_wreg_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed cycle-by-cycle checks of id_hazard_ctrl; expected outputs packed as
// {stall, bubble, issue, md_start, md_is_div, md_busy}.
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0, id_func = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wreg = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wen = 1'b0;
  logic       mem_stall = 1'b0;
  logic       stall, bubble, issue, md_start, md_is_div, md_busy;

  id_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wen(id_wen),
    .mem_stall(mem_stall), .stall(stall), .bubble(bubble), .issue(issue),
    .md_start(md_start), .md_is_div(md_is_div), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, wreg;
    logic       urs, urt, wen;
  } ins_t;

  typedef struct {
    logic       r, ms;
    ins_t       in;
    logic [5:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  function automatic ins_t mk(input logic [5:0] op, fn, input logic [4:0] rs, rt, wreg,
                              input logic urs, urt, wen);
    ins_t i;
    i.valid = 1'b1; i.op = op; i.fn = fn; i.rs = rs; i.rt = rt; i.wreg = wreg;
    i.urs = urs; i.urt = urt; i.wen = wen;
    return i;
  endfunction

  function automatic ins_t NOP();
    ins_t i = mk(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    i.valid = 1'b0;
    return i;
  endfunction
  function automatic ins_t LW(input logic [4:0] rt, rs);
    return mk(6'h23, 6'h00, rs, rt, rt, 1'b1, 1'b0, 1'b1);
  endfunction
  function automatic ins_t ADDU(input logic [4:0] rd, rs, rt);
    return mk(6'h00, 6'h21, rs, rt, rd, 1'b1, 1'b1, 1'b1);
  endfunction
  function automatic ins_t JR(input logic [4:0] rs);
    return mk(6'h00, 6'h08, rs, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic ins_t MD(input logic [5:0] fn);
    return mk(6'h00, fn, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic ins_t MF(input logic [5:0] fn, input logic [4:0] rd);
    return mk(6'h00, fn, 5'd0, 5'd0, rd, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic vec_t V(input logic r, ms, input ins_t i, input logic [5:0] e);
    vec_t v;
    v.r = r; v.ms = ms; v.in = i; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    logic [5:0] act;
    @(posedge clk);
    #1;
    rst = v.r; mem_stall = v.ms;
    id_valid = v.in.valid; id_opcode = v.in.op; id_func = v.in.fn;
    id_rs = v.in.rs; id_rt = v.in.rt; id_wreg = v.in.wreg;
    id_use_rs = v.in.urs; id_use_rt = v.in.urt; id_wen = v.in.wen;
    @(negedge clk);
    act = {stall, bubble, issue, md_start, md_is_div, md_busy};
    checks++;
    if (act !== v.exp) begin
      failures++;
      $display("FAIL %s: got s/b/i/ms/md/bz=%b expected %b", nm, act, v.exp);
    end
  endtask

  initial begin
    // reset, load-use, jr dependencies, mult/mflo, div issue
    tbl.push_back(V(1, 0, NOP(), 6'b000000));
    tbl.push_back(V(1, 1, NOP(), 6'b100000));
    tbl.push_back(V(0, 0, LW(5'd8, 5'd9), 6'b001000));
    tbl.push_back(V(0, 0, ADDU(5'd9, 5'd8, 5'd10), 6'b110000));
    tbl.push_back(V(0, 0, ADDU(5'd9, 5'd8, 5'd10), 6'b001000));
    tbl.push_back(V(0, 0, ADDU(5'd4, 5'd1, 5'd2), 6'b001000));
    tbl.push_back(V(0, 0, JR(5'd4), 6'b110000));
    tbl.push_back(V(0, 0, JR(5'd4), 6'b001000));
    tbl.push_back(V(0, 0, LW(5'd4, 5'd1), 6'b001000));
    tbl.push_back(V(0, 0, JR(5'd4), 6'b110000));
    tbl.push_back(V(0, 0, JR(5'd4), 6'b110000));
    tbl.push_back(V(0, 0, JR(5'd4), 6'b001000));
    tbl.push_back(V(0, 0, LW(5'd0, 5'd1), 6'b001000));
    tbl.push_back(V(0, 0, JR(5'd0), 6'b001000));
    tbl.push_back(V(0, 0, JR(5'd0), 6'b001000));
    tbl.push_back(V(0, 0, MD(6'h18), 6'b001100));
    for (int k = 0; k < 4; k++) tbl.push_back(V(0, 0, MF(6'h12, 5'd3), 6'b110001));
    tbl.push_back(V(0, 0, MF(6'h12, 5'd3), 6'b001000));
    tbl.push_back(V(0, 0, MD(6'h1A), 6'b001110));
    tbl.push_back(V(0, 0, ADDU(5'd5, 5'd6, 5'd7), 6'b001001));

    foreach (tbl[k]) apply(tbl[k], $sformatf("vec%0d", k));

    // divu waits out the remaining 32 busy cycles of the div
    for (int k = 0; k < 32; k++) apply(V(0, 0, MD(6'h1B), 6'b110001), $sformatf("divu_wait%0d", k));
    apply(V(0, 0, MD(6'h1B), 6'b001110), "divu_issue");

    // reset in the middle of the divu busy period
    apply(V(0, 0, LW(5'd7, 5'd1), 6'b001001), "lw_during_div");
    apply(V(1, 0, NOP(), 6'b000001), "rst_cycle_busy");
    apply(V(0, 0, ADDU(5'd8, 5'd7, 5'd7), 6'b001000), "post_rst_tracker_clear");
    apply(V(0, 0, MF(6'h10, 5'd3), 6'b001000), "post_rst_mfhi");

    // mem_stall over a pending load-use hazard freezes the tracker
    apply(V(0, 0, LW(5'd8, 5'd9), 6'b001000), "ms_lw");
    for (int k = 0; k < 3; k++) apply(V(0, 1, ADDU(5'd9, 5'd8, 5'd0), 6'b100000), $sformatf("ms_hold%0d", k));
    apply(V(0, 0, ADDU(5'd9, 5'd8, 5'd0), 6'b110000), "ms_release_bubble");
    apply(V(0, 0, ADDU(5'd9, 5'd8, 5'd0), 6'b001000), "ms_release_issue");

    // no md_start under mem_stall; counter still runs during mem_stall
    apply(V(0, 1, MD(6'h19), 6'b100000), "multu_ms_hold");
    apply(V(0, 0, MD(6'h19), 6'b001100), "multu_issue");
    apply(V(0, 1, NOP(), 6'b100001), "cnt4_ms");
    apply(V(0, 0, NOP(), 6'b000001), "cnt3");
    apply(V(0, 0, NOP(), 6'b000001), "cnt2");
    apply(V(0, 0, NOP(), 6'b000001), "cnt1");
    apply(V(0, 0, NOP(), 6'b000000), "cnt0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
